// File: rtl/ultrasonic_echo_emulator_if.sv
// Trig/echo pin bundle between a ranging controller (master) and the
// ultrasonic sensor emulator (slave), plus the emulator's status strobes.
`timescale 1ns/1ps

interface ultrasonic_echo_emulator_if;
  logic        trig;
  logic [15:0] echo_us;
  logic        echo;
  logic        busy;
  logic        no_target;
  logic        trig_short;
  logic        trig_ignored;

  modport master (
    output trig,
    output echo_us,
    input  echo,
    input  busy,
    input  no_target,
    input  trig_short,
    input  trig_ignored
  );

  modport slave (
    input  trig,
    input  echo_us,
    output echo,
    output busy,
    output no_target,
    output trig_short,
    output trig_ignored
  );
endinterface

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04-style sensor model: validates trig width, waits the burst delay,
// then drives echo for the programmed number of microseconds.
`timescale 1ns/1ps

module ultrasonic_echo_emulator #(
  parameter int US_TICKS    = 100,
  parameter int MIN_TRIG_US = 10,
  parameter int BURST_US    = 200,
  parameter int MAX_ECHO_US = 38000,
  parameter int HOLDOFF_US  = 60000
) (
  input  logic                     clk100,
  input  logic                     rstn,
  ultrasonic_echo_emulator_if.slave bus
);

  localparam int MIN_CYC = MIN_TRIG_US * US_TICKS;
  localparam int WID_W   = $clog2(MIN_CYC + 1);
  localparam int PRE_W   = (US_TICKS > 1) ? $clog2(US_TICKS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(US_TICKS - 1);
  localparam logic [WID_W-1:0] WID_MAX    = WID_W'(MIN_CYC);
  // The rise cycle itself is not counted, so a width of MIN_CYC shows up as MIN_CYC-1.
  localparam logic [WID_W-1:0] WID_THR    = WID_W'(MIN_CYC - 1);
  localparam logic [15:0]      MAX_ECHO   = 16'(MAX_ECHO_US);
  localparam logic [15:0]      BURST_LAST = 16'(BURST_US - 1);
  localparam logic [15:0]      HOLD_LAST  = 16'(HOLDOFF_US - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG_HI = 3'd1,
    ST_BURST   = 3'd2,
    ST_ECHO    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               s3_q, s3_d;
  logic [WID_W-1:0]   wid_q, wid_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [15:0]        us_q, us_d;
  logic [15:0]        len_q, len_d;
  logic               echo_q, echo_d;
  logic               busy_q, busy_d;
  logic               no_target_q, no_target_d;
  logic               trig_short_q, trig_short_d;
  logic               trig_ignored_q, trig_ignored_d;

  logic               rise;
  logic               fall;
  logic               tick;
  logic               expire;
  logic               out_of_range;
  logic [15:0]        last_us;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_comb begin
    s1_d           = bus.trig;
    s2_d           = s1_q;
    s3_d           = s2_q;
    state_d        = state_q;
    wid_d          = wid_q;
    pre_d          = pre_q;
    us_d           = us_q;
    len_d          = len_q;
    no_target_d    = no_target_q;
    trig_short_d   = 1'b0;
    trig_ignored_d = 1'b0;
    out_of_range   = (bus.echo_us == 16'd0) || (bus.echo_us > MAX_ECHO);

    case (state_q)
      ST_BURST: last_us = BURST_LAST;
      ST_ECHO:  last_us = len_q - 16'd1;
      default:  last_us = HOLD_LAST;
    endcase
    tick   = (pre_q == PRE_LAST);
    expire = tick && (us_q == last_us);

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_TRIG_HI;
          wid_d   = '0;
        end
      end
      ST_TRIG_HI: begin
        if (fall) begin
          if (wid_q >= WID_THR) begin
            len_d       = out_of_range ? MAX_ECHO : bus.echo_us;
            no_target_d = out_of_range;
            pre_d       = '0;
            us_d        = '0;
            state_d     = ST_BURST;
          end else begin
            trig_short_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end else if (s2_q && (wid_q != WID_MAX)) begin
          wid_d = wid_q + 1'b1;
        end
      end
      ST_BURST, ST_ECHO, ST_HOLDOFF: begin
        trig_ignored_d = rise;
        if (expire) begin
          pre_d   = '0;
          us_d    = '0;
          state_d = (state_q == ST_BURST) ? ST_ECHO :
                    (state_q == ST_ECHO)  ? ST_HOLDOFF : ST_IDLE;
        end else if (tick) begin
          pre_d = '0;
          us_d  = us_q + 16'd1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they align with the transition edge.
    echo_d = (state_d == ST_ECHO);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      wid_q          <= '0;
      pre_q          <= '0;
      us_q           <= '0;
      len_q          <= '0;
      echo_q         <= 1'b0;
      busy_q         <= 1'b0;
      no_target_q    <= 1'b0;
      trig_short_q   <= 1'b0;
      trig_ignored_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      wid_q          <= wid_d;
      pre_q          <= pre_d;
      us_q           <= us_d;
      len_q          <= len_d;
      echo_q         <= echo_d;
      busy_q         <= busy_d;
      no_target_q    <= no_target_d;
      trig_short_q   <= trig_short_d;
      trig_ignored_q <= trig_ignored_d;
    end
  end

  assign bus.echo         = echo_q;
  assign bus.busy         = busy_q;
  assign bus.no_target    = no_target_q;
  assign bus.trig_short   = trig_short_q;
  assign bus.trig_ignored = trig_ignored_q;

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Scoreboard bench for the echo emulator, run with scaled-down timing
// parameters so every scenario fits in a short simulation.
`timescale 1ns/1ps

module tb_ultrasonic_echo_emulator;
  localparam int T   = 10;
  localparam int MIN = 10;
  localparam int B   = 20;
  localparam int MX  = 200;
  localparam int H   = 30;
  localparam int BUDGET = (B + MX + H) * T + 500;

  typedef struct {
    int rise;
    int width;
    int nt;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  int   in_echo = 0;
  int   rise_cyc = 0;
  int   echo_fall_cyc = 0;
  int   rise_cnt = 0;
  int   short_cnt = 0;
  int   short_cyc = 0;
  int   ign_cnt = 0;

  ultrasonic_echo_emulator_if bus_if();

  ultrasonic_echo_emulator #(
    .US_TICKS   (T),
    .MIN_TRIG_US(MIN),
    .BURST_US   (B),
    .MAX_ECHO_US(MX),
    .HOLDOFF_US (H)
  ) dut (
    .clk100(clk),
    .rstn  (rstn),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_len(input int eus);
    return (eus == 0 || eus > MX) ? MX : eus;
  endfunction

  function automatic int model_nt(input int eus);
    return (eus == 0 || eus > MX) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (!rstn) begin
      in_echo = 0;
    end else begin
      if (bus_if.trig_short) begin
        short_cnt++;
        short_cyc = cyc;
      end
      if (bus_if.trig_ignored) ign_cnt++;
      if (bus_if.echo && in_echo == 0) begin
        in_echo = 1;
        rise_cyc = cyc;
        rise_cnt++;
        check("busy_at_echo", int'(bus_if.busy), 1);
      end else if (!bus_if.echo && in_echo == 1) begin
        exp_t e;
        in_echo = 0;
        echo_fall_cyc = cyc;
        if (sb.size() == 0) begin
          check("echo_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("echo_rise", rise_cyc, e.rise);
          check("echo_width", cyc - rise_cyc, e.width);
          check("no_target", int'(bus_if.no_target), e.nt);
        end
      end
    end
  end

  task automatic pulse_trig(input int w, output int k);
    @(negedge clk);
    bus_if.trig = 1'b1;
    repeat (w) @(negedge clk);
    bus_if.trig = 1'b0;
    k = cyc + 1;
  endtask

  task automatic wait_busy_low(output int at);
    int n = 0;
    at = -1;
    while (bus_if.busy && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (bus_if.busy) check("idle_timeout", 1, 0);
    else at = cyc;
  endtask

  task automatic wait_echo(input logic val);
    int n = 0;
    while (bus_if.echo !== val && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (bus_if.echo !== val) check("echo_timeout", int'(bus_if.echo), int'(val));
  endtask

  task automatic start_meas(input int w, input int eus);
    int k;
    bus_if.echo_us = 16'(eus);
    pulse_trig(w, k);
    sb.push_back('{rise: k + 2 + B * T, width: model_len(eus) * T, nt: model_nt(eus)});
  endtask

  task automatic finish_meas(input string tag);
    int t;
    wait_busy_low(t);
    if (t >= 0) check(tag, t - echo_fall_cyc, H * T);
  endtask

  task automatic run_meas(input int w, input int eus);
    start_meas(w, eus);
    finish_meas("busy_fall");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, s0, r0, i0;
    rstn = 1'b0;
    bus_if.trig = 1'b0;
    bus_if.echo_us = 16'd0;
    repeat (4) @(negedge clk);
    check("rst_echo", int'(bus_if.echo), 0);
    check("rst_busy", int'(bus_if.busy), 0);
    check("rst_no_target", int'(bus_if.no_target), 0);
    check("rst_trig_short", int'(bus_if.trig_short), 0);
    check("rst_trig_ignored", int'(bus_if.trig_ignored), 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    run_meas(MIN * T, 58);

    // Just-too-short trig is rejected, the minimum width is accepted.
    s0 = short_cnt;
    r0 = rise_cnt;
    bus_if.echo_us = 16'd58;
    pulse_trig(MIN * T - 1, k);
    repeat (5) @(negedge clk);
    check("short_count", short_cnt - s0, 1);
    check("short_align", short_cyc, k + 2);
    check("short_busy", int'(bus_if.busy), 0);
    repeat ((B + 5) * T) @(negedge clk);
    check("short_no_echo", rise_cnt - r0, 0);
    run_meas(MIN * T, 58);

    run_meas(MIN * T, 0);
    s0 = short_cnt;
    pulse_trig(MIN * T / 2, k);
    repeat (5) @(negedge clk);
    check("short_keeps_nt", int'(bus_if.no_target), 1);
    check("short_count2", short_cnt - s0, 1);
    run_meas(MIN * T, 40000);
    run_meas(MIN * T, MX);
    run_meas(MIN * T, MX + 1);
    run_meas(MIN * T, 10);

    // Re-triggers during ECHO and HOLDOFF are flagged and otherwise ignored.
    start_meas(MIN * T, 50);
    wait_echo(1'b1);
    i0 = ign_cnt;
    pulse_trig(MIN * T, k);
    repeat (4) @(negedge clk);
    check("ign_in_echo", ign_cnt - i0, 1);
    wait_echo(1'b0);
    i0 = ign_cnt;
    pulse_trig(MIN * T, k);
    repeat (4) @(negedge clk);
    check("ign_in_holdoff", ign_cnt - i0, 1);
    finish_meas("busy_fall_retrig");
    i0 = ign_cnt;
    r0 = rise_cnt;
    run_meas(MIN * T, 20);
    check("retrig_accepted", rise_cnt - r0, 1);
    check("retrig_not_ignored", ign_cnt - i0, 0);

    // echo_us changes after the latch do not alter the measurement.
    start_meas(MIN * T, 30);
    repeat (B * T / 4) @(negedge clk);
    bus_if.echo_us = 16'd70;
    finish_meas("busy_fall_latch");

    // Reset in the middle of an echo.
    start_meas(MIN * T, 0);
    wait_echo(1'b1);
    repeat (50) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_mid_echo", int'(bus_if.echo), 0);
    check("rst_mid_busy", int'(bus_if.busy), 0);
    check("rst_mid_nt", int'(bus_if.no_target), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    run_meas(MIN * T, 58);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
